rob_retire_ctrl: RTL and testbench



---
 rtl/rob_pkg.sv | 25 ++
 rtl/rob_retire_ctrl_if.sv | 40 ++++
 rtl/rob_done_mem.sv | 48 ++++
 rtl/rob_retire_ctrl.sv | 93 +++++++++
 tb/tb_rob_retire_ctrl.sv | 298 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/rob_pkg.sv
// Shared constants and pointer helpers for the reorder-buffer retire controller.
// Imported by the interface, the done-bit store and the controller top.
package rob_pkg;

  localparam int ROB_ADDR_WIDTH = 4;
  localparam int ROB_DATA_WIDTH = 8;

  // True when id sits inside the occupied window [head, tail), modulo the ring.
  // Pointers carry a wrap bit above addr_width; id is a plain entry index.
  function automatic logic id_in_window(input logic [31:0] id,
                                        input logic [31:0] head,
                                        input logic [31:0] tail,
                                        input int unsigned addr_width);
    logic [31:0] idx_mask;
    logic [31:0] ptr_mask;
    logic [31:0] offset;
    logic [31:0] occupancy;
    idx_mask  = (32'd1 << addr_width) - 32'd1;
    ptr_mask  = (32'd1 << (addr_width + 1)) - 32'd1;
    offset    = (id - head) & idx_mask;
    occupancy = (tail - head) & ptr_mask;
    return offset < occupancy;
  endfunction

endpackage

// File: rtl/rob_retire_ctrl_if.sv
// Issue, completion, retire and flush signals of the ROB retire controller.
// master = surrounding pipeline, slave = the controller.
interface rob_retire_ctrl_if
  import rob_pkg::*;
#(
  parameter int ADDR_WIDTH = ROB_ADDR_WIDTH,
  parameter int DATA_WIDTH = ROB_DATA_WIDTH
);

  logic                  alloc_valid_i;
  logic                  alloc_ready_o;
  logic [ADDR_WIDTH-1:0] alloc_id_o;

  logic                  cmpl_valid_i;
  logic [ADDR_WIDTH-1:0] cmpl_id_i;
  logic [DATA_WIDTH-1:0] cmpl_data_i;

  logic                  ret_valid_o;
  logic                  ret_ready_i;
  logic [ADDR_WIDTH-1:0] ret_id_o;
  logic [DATA_WIDTH-1:0] ret_data_o;

  logic                  flush_i;
  logic [ADDR_WIDTH:0]   count_o;
  logic                  empty_o;
  logic                  full_o;

  modport master (
    output alloc_valid_i, cmpl_valid_i, cmpl_id_i, cmpl_data_i, ret_ready_i, flush_i,
    input  alloc_ready_o, alloc_id_o, ret_valid_o, ret_id_o, ret_data_o,
           count_o, empty_o, full_o
  );

  modport slave (
    input  alloc_valid_i, cmpl_valid_i, cmpl_id_i, cmpl_data_i, ret_ready_i, flush_i,
    output alloc_ready_o, alloc_id_o, ret_valid_o, ret_id_o, ret_data_o,
           count_o, empty_o, full_o
  );

endinterface

// File: rtl/rob_done_mem.sv
// Per-entry "completion arrived" bits: set on completion, cleared on retire,
// on allocation and globally on flush; two asynchronous read ports.
module rob_done_mem
  import rob_pkg::*;
#(
  parameter int ADDR_WIDTH = ROB_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  set_en,
  input  logic [ADDR_WIDTH-1:0] set_idx,
  input  logic                  clr_en,
  input  logic [ADDR_WIDTH-1:0] clr_idx,
  input  logic                  alloc_clr_en,
  input  logic [ADDR_WIDTH-1:0] alloc_clr_idx,
  input  logic [ADDR_WIDTH-1:0] head_idx,
  output logic                  head_done,
  input  logic [ADDR_WIDTH-1:0] probe_idx,
  output logic                  probe_done
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [DEPTH-1:0] done_q;

  // The controller guarantees set, retire-clear and alloc-clear never target
  // the same entry in one cycle, so the priority below is only a tie-break.
  always_ff @(posedge clk) begin
    // NOTE: state is assigned with <= so every bit samples pre-edge values.
    if (!rst_n || flush) begin
      done_q <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (set_en && set_idx == ADDR_WIDTH'(i)) begin
          done_q[i] <= 1'b1;
        end else if ((clr_en && clr_idx == ADDR_WIDTH'(i)) ||
                     (alloc_clr_en && alloc_clr_idx == ADDR_WIDTH'(i))) begin
          done_q[i] <= 1'b0;
        end
      end
    end
  end

  assign head_done  = done_q[head_idx];
  assign probe_done = done_q[probe_idx];

endmodule

// File: rtl/rob_retire_ctrl.sv
// In-order allocate / out-of-order complete / in-order retire controller for
// the reorder buffer: owns head/tail pointers, done bits and the payload array.
module rob_retire_ctrl
  import rob_pkg::*;
#(
  parameter int ADDR_WIDTH = ROB_ADDR_WIDTH,
  parameter int DATA_WIDTH = ROB_DATA_WIDTH
) (
  input  logic               clk,
  input  logic               rst_n,
  rob_retire_ctrl_if.slave   bus
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam int PTR_W = ADDR_WIDTH + 1;

  logic [PTR_W-1:0]      head_q;
  logic [PTR_W-1:0]      tail_q;
  logic [PTR_W-1:0]      count;
  logic [ADDR_WIDTH-1:0] head_idx;
  logic [ADDR_WIDTH-1:0] tail_idx;
  logic                  empty;
  logic                  full;
  logic                  alloc_ready;
  logic                  alloc_fire;
  logic                  ret_valid;
  logic                  ret_fire;
  logic                  cmpl_in_window;
  logic                  cmpl_fire;
  logic                  head_done;
  logic                  cmpl_done;
  logic [DATA_WIDTH-1:0] payload_q [DEPTH];

  assign head_idx = head_q[ADDR_WIDTH-1:0];
  assign tail_idx = tail_q[ADDR_WIDTH-1:0];
  assign count    = tail_q - head_q;
  assign empty    = (head_q == tail_q);
  // Same slot but opposite wrap bits: the ring has lapped the head exactly once.
  assign full     = (head_idx == tail_idx) && (head_q[ADDR_WIDTH] != tail_q[ADDR_WIDTH]);

  // Flush suppresses every handshake in its cycle.
  assign alloc_ready = !full && !bus.flush_i;
  assign alloc_fire  = bus.alloc_valid_i && alloc_ready;
  assign ret_valid   = !empty && head_done && !bus.flush_i;
  assign ret_fire    = ret_valid && bus.ret_ready_i;

  assign cmpl_in_window = id_in_window(32'(bus.cmpl_id_i), 32'(head_q), 32'(tail_q), ADDR_WIDTH);
  assign cmpl_fire      = bus.cmpl_valid_i && !bus.flush_i && cmpl_in_window && !cmpl_done;

  always_ff @(posedge clk) begin
    if (!rst_n || bus.flush_i) begin
      head_q <= '0;
      tail_q <= '0;
    end else begin
      if (alloc_fire) tail_q <= tail_q + PTR_W'(1);
      if (ret_fire)   head_q <= head_q + PTR_W'(1);
    end
  end

  // NOTE: the payload array is deliberately left out of reset; the done bits
  // already mark which entries hold valid data, so only they are cleared.
  always_ff @(posedge clk) begin
    if (rst_n && cmpl_fire) payload_q[bus.cmpl_id_i] <= bus.cmpl_data_i;
  end

  rob_done_mem #(
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_done_mem (
    .clk           (clk),
    .rst_n         (rst_n),
    .flush         (bus.flush_i),
    .set_en        (cmpl_fire),
    .set_idx       (bus.cmpl_id_i),
    .clr_en        (ret_fire),
    .clr_idx       (head_idx),
    .alloc_clr_en  (alloc_fire),
    .alloc_clr_idx (tail_idx),
    .head_idx      (head_idx),
    .head_done     (head_done),
    .probe_idx     (bus.cmpl_id_i),
    .probe_done    (cmpl_done)
  );

  assign bus.alloc_ready_o = alloc_ready;
  assign bus.alloc_id_o    = tail_idx;
  assign bus.ret_valid_o   = ret_valid;
  assign bus.ret_id_o      = head_idx;
  assign bus.ret_data_o    = payload_q[head_idx];
  assign bus.count_o       = count;
  assign bus.empty_o       = empty;
  assign bus.full_o        = full;

endmodule

// File: tb/tb_rob_retire_ctrl.sv
// Directed bench for rob_retire_ctrl: expected retires are queued as stimulus
// is issued and a negedge monitor pops and compares every retire handshake.
module tb_rob_retire_ctrl;

  typedef struct packed {
    logic [3:0] id;
    logic [7:0] data;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   failures = 0;
  exp_t exp_q[$];

  always #5 clk = ~clk;

  rob_retire_ctrl_if #(.ADDR_WIDTH(4), .DATA_WIDTH(8)) bus ();

  rob_retire_ctrl #(.ADDR_WIDTH(4), .DATA_WIDTH(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic av, input logic cv, input logic [3:0] cid,
                       input logic [7:0] cd, input logic rr, input logic fl);
    bus.alloc_valid_i = av;
    bus.cmpl_valid_i  = cv;
    bus.cmpl_id_i     = cid;
    bus.cmpl_data_i   = cd;
    bus.ret_ready_i   = rr;
    bus.flush_i       = fl;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input logic [3:0] id, input logic [7:0] data);
    exp_t e;
    e.id   = id;
    e.data = data;
    exp_q.push_back(e);
  endtask

  function automatic logic [7:0] seq_data(input int s);
    return 8'(s * 37 + 11);
  endfunction

  // Retire monitor: any accepted retire must match the head of the queue.
  always @(negedge clk) begin
    if (rst_n && bus.ret_valid_o && bus.ret_ready_i) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_retire: got id %0h data %0h with nothing expected",
                 bus.ret_id_o, bus.ret_data_o);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("ret_id", 32'(bus.ret_id_o), 32'(e.id));
        check("ret_data", 32'(bus.ret_data_o), 32'(e.data));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    drive(1'b0, 1'b0, 4'd0, 8'd0, 1'b0, 1'b0);
    rst_n = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;

    // Reset state
    @(negedge clk);
    check("rst_alloc_ready", 32'(bus.alloc_ready_o), 32'd1);
    check("rst_ret_valid", 32'(bus.ret_valid_o), 32'd0);
    check("rst_count", 32'(bus.count_o), 32'd0);
    check("rst_empty", 32'(bus.empty_o), 32'd1);
    check("rst_full", 32'(bus.full_o), 32'd0);
    check("rst_ret_id", 32'(bus.ret_id_o), 32'd0);
    check("rst_alloc_id", 32'(bus.alloc_id_o), 32'd0);
    tick();

    // Alloc 3, complete out of order 2,0,1, retire in order
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 1'b0, 4'd0, 8'd0, 1'b1, 1'b0);
      @(negedge clk);
      check("t1_alloc_id", 32'(bus.alloc_id_o), 32'(k));
      tick();
    end
    push_exp(4'd0, 8'hA0);
    push_exp(4'd1, 8'hA1);
    push_exp(4'd2, 8'hA2);
    drive(1'b0, 1'b1, 4'd2, 8'hA2, 1'b1, 1'b0);
    @(negedge clk);
    check("t1_count3", 32'(bus.count_o), 32'd3);
    check("t1_valid_c2", 32'(bus.ret_valid_o), 32'd0);
    tick();
    drive(1'b0, 1'b1, 4'd0, 8'hA0, 1'b1, 1'b0);
    @(negedge clk);
    check("t1_no_bypass", 32'(bus.ret_valid_o), 32'd0);
    tick();
    drive(1'b0, 1'b1, 4'd1, 8'hA1, 1'b1, 1'b0);
    @(negedge clk);
    check("t1_valid_after_c0", 32'(bus.ret_valid_o), 32'd1);
    tick();
    drive(1'b0, 1'b0, 4'd0, 8'd0, 1'b1, 1'b0);
    repeat (2) begin
      @(negedge clk);
      check("t1_drain_valid", 32'(bus.ret_valid_o), 32'd1);
      tick();
    end
    @(negedge clk);
    check("t1_empty", 32'(bus.empty_o), 32'd1);
    check("t1_count0", 32'(bus.count_o), 32'd0);
    check("t1_ret_id_next", 32'(bus.ret_id_o), 32'd3);
    tick();

    // Completion to unallocated ID 7 with head=tail=3
    drive(1'b0, 1'b1, 4'd7, 8'h77, 1'b0, 1'b0);
    @(negedge clk);
    tick();
    drive(1'b0, 1'b0, 4'd0, 8'd0, 1'b0, 1'b0);
    @(negedge clk);
    check("t4_unalloc_valid", 32'(bus.ret_valid_o), 32'd0);
    check("t4_unalloc_count", 32'(bus.count_o), 32'd0);
    tick();

    // Duplicate completion keeps the first payload
    drive(1'b1, 1'b0, 4'd0, 8'd0, 1'b0, 1'b0);
    @(negedge clk);
    check("t4_alloc_id", 32'(bus.alloc_id_o), 32'd3);
    tick();
    drive(1'b0, 1'b1, 4'd3, 8'h31, 1'b0, 1'b0);
    @(negedge clk);
    check("t4_not_done_yet", 32'(bus.ret_valid_o), 32'd0);
    tick();
    drive(1'b0, 1'b1, 4'd3, 8'h99, 1'b0, 1'b0);
    @(negedge clk);
    check("t4_valid", 32'(bus.ret_valid_o), 32'd1);
    check("t4_data_first", 32'(bus.ret_data_o), 32'h31);
    tick();
    drive(1'b0, 1'b0, 4'd0, 8'd0, 1'b0, 1'b0);
    @(negedge clk);
    check("t4_dup_ignored", 32'(bus.ret_data_o), 32'h31);
    tick();
    push_exp(4'd3, 8'h31);
    drive(1'b0, 1'b0, 4'd0, 8'd0, 1'b1, 1'b0);
    @(negedge clk);
    tick();
    drive(1'b0, 1'b0, 4'd0, 8'd0, 1'b0, 1'b0);
    @(negedge clk);
    check("t4_count_after", 32'(bus.count_o), 32'd0);
    tick();

    // Flush back to ID 0, then fill 16
    drive(1'b0, 1'b0, 4'd0, 8'd0, 1'b0, 1'b1);
    tick();
    for (int k = 0; k < 16; k++) begin
      drive(1'b1, 1'b0, 4'd0, 8'd0, 1'b0, 1'b0);
      @(negedge clk);
      check("t2_fill_id", 32'(bus.alloc_id_o), 32'(k));
      tick();
    end
    @(negedge clk);
    check("t2_full", 32'(bus.full_o), 32'd1);
    check("t2_alloc_ready", 32'(bus.alloc_ready_o), 32'd0);
    check("t2_count16", 32'(bus.count_o), 32'd16);
    check("t2_not_empty", 32'(bus.empty_o), 32'd0);
    tick();
    drive(1'b1, 1'b1, 4'd0, 8'hC0, 1'b0, 1'b0);
    @(negedge clk);
    tick();
    push_exp(4'd0, 8'hC0);
    drive(1'b1, 1'b0, 4'd0, 8'd0, 1'b1, 1'b0);
    @(negedge clk);
    check("t2_ret_while_full", 32'(bus.ret_valid_o), 32'd1);
    check("t2_ready_still_low", 32'(bus.alloc_ready_o), 32'd0);
    tick();
    drive(1'b1, 1'b0, 4'd0, 8'd0, 1'b0, 1'b0);
    @(negedge clk);
    check("t2_ready_next", 32'(bus.alloc_ready_o), 32'd1);
    check("t2_wrap_id", 32'(bus.alloc_id_o), 32'd0);
    check("t2_count15", 32'(bus.count_o), 32'd15);
    tick();
    drive(1'b0, 1'b0, 4'd0, 8'd0, 1'b0, 1'b0);
    @(negedge clk);
    check("t2_refull", 32'(bus.full_o), 32'd1);
    tick();

    // Head completes with ready low: held stable for 5 cycles
    drive(1'b0, 1'b1, 4'd1, 8'h5A, 1'b0, 1'b0);
    @(negedge clk);
    tick();
    drive(1'b0, 1'b0, 4'd0, 8'd0, 1'b0, 1'b0);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("t3_hold_valid", 32'(bus.ret_valid_o), 32'd1);
      check("t3_hold_id", 32'(bus.ret_id_o), 32'd1);
      check("t3_hold_data", 32'(bus.ret_data_o), 32'h5A);
      tick();
    end
    push_exp(4'd1, 8'h5A);
    drive(1'b0, 1'b0, 4'd0, 8'd0, 1'b1, 1'b0);
    @(negedge clk);
    tick();
    drive(1'b0, 1'b0, 4'd0, 8'd0, 1'b0, 1'b0);
    @(negedge clk);
    check("t3_count15", 32'(bus.count_o), 32'd15);
    tick();

    // Flush with 10 outstanding, 4 done, alloc/cmpl/retire all requested
    drive(1'b0, 1'b0, 4'd0, 8'd0, 1'b0, 1'b1);
    tick();
    for (int k = 0; k < 10; k++) begin
      drive(1'b1, 1'b0, 4'd0, 8'd0, 1'b0, 1'b0);
      tick();
    end
    for (int k = 0; k < 4; k++) begin
      drive(1'b0, 1'b1, 4'(2 * k), 8'(8'h40 + k), 1'b0, 1'b0);
      tick();
    end
    drive(1'b0, 1'b0, 4'd0, 8'd0, 1'b0, 1'b0);
    @(negedge clk);
    check("t5_count10", 32'(bus.count_o), 32'd10);
    check("t5_head_done", 32'(bus.ret_valid_o), 32'd1);
    tick();
    drive(1'b1, 1'b1, 4'd8, 8'h88, 1'b1, 1'b1);
    @(negedge clk);
    check("t5_flush_alloc_ready", 32'(bus.alloc_ready_o), 32'd0);
    check("t5_flush_ret_valid", 32'(bus.ret_valid_o), 32'd0);
    tick();
    drive(1'b0, 1'b0, 4'd0, 8'd0, 1'b0, 1'b0);
    @(negedge clk);
    check("t5_count0", 32'(bus.count_o), 32'd0);
    check("t5_empty", 32'(bus.empty_o), 32'd1);
    check("t5_ret_valid", 32'(bus.ret_valid_o), 32'd0);
    check("t5_alloc_id", 32'(bus.alloc_id_o), 32'd0);
    check("t5_full", 32'(bus.full_o), 32'd0);
    tick();
    drive(1'b1, 1'b0, 4'd0, 8'd0, 1'b0, 1'b0);
    tick();
    drive(1'b0, 1'b0, 4'd0, 8'd0, 1'b0, 1'b0);
    @(negedge clk);
    check("t5_done_cleared", 32'(bus.ret_valid_o), 32'd0);
    check("t5_count1", 32'(bus.count_o), 32'd1);
    tick();

    // Steady alloc+retire every cycle at occupancy 5, across the wrap
    drive(1'b0, 1'b0, 4'd0, 8'd0, 1'b0, 1'b1);
    tick();
    for (int s = 0; s < 45; s++) push_exp(4'(s), seq_data(s));
    for (int s = 0; s < 5; s++) begin
      drive(1'b1, 1'b0, 4'd0, 8'd0, 1'b0, 1'b0);
      tick();
    end
    for (int s = 0; s < 5; s++) begin
      drive(1'b0, 1'b1, 4'(s), seq_data(s), 1'b0, 1'b0);
      tick();
    end
    for (int k = 0; k < 40; k++) begin
      drive(1'b1, (k > 0), 4'(4 + k), seq_data(4 + k), 1'b1, 1'b0);
      @(negedge clk);
      check("t6_count5", 32'(bus.count_o), 32'd5);
      check("t6_alloc_id", 32'(bus.alloc_id_o), 32'((5 + k) % 16));
      tick();
    end
    drive(1'b0, 1'b1, 4'(44), seq_data(44), 1'b1, 1'b0);
    tick();
    drive(1'b0, 1'b0, 4'd0, 8'd0, 1'b1, 1'b0);
    for (int k = 0; k < 50 && exp_q.size() != 0; k++) tick();
    check("t6_all_retired", 32'(exp_q.size()), 32'd0);
    @(negedge clk);
    check("t6_final_count", 32'(bus.count_o), 32'd0);
    check("t6_final_empty", 32'(bus.empty_o), 32'd1);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
